// File: rtl/spi_slave_mem_burst.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_mem_burst
// Function : SPI mode-0 slave with an internal register-file memory. Supports
//            single and burst read/write, optional address wrap, rejection
//            of invalid opcodes and defined chip-select abort behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_mem_burst #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int BURST_WRAP  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic sclk,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic cmd_err,
  output logic abort
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int HDR_W   = 3 + ADDR_W;
  localparam int CNT_MAX = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_WR   = 3'd2,
    S_RD   = 3'd3,
    S_IGN  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic cs_prev, sclk_prev;
  logic cs_s, sclk_s, mosi_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [HDR_W-2:0]  hdr_shift;
  logic [HDR_W-1:0]  hdr_next;
  logic [DATA_W-1:0] wr_shift;
  logic [DATA_W-1:0] rd_shift;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr;
  logic burst, past_end, commit_pend, load_pend;
  logic hdr_done, word_done;

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  // cs resets to "low" so a frame already running when reset releases is
  // not mistaken for a new one: a fall needs cs to be seen high first.
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign sclk_rise = ~sclk_prev & sclk_s;
  assign sclk_fall = sclk_prev & ~sclk_s;
  assign hdr_next  = {hdr_shift, mosi_s};
  assign busy      = ~cs_s & (state != S_IDLE);

  // Synchronise the asynchronous SPI pins and keep the previous samples for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode; a cs rise overrides everything outside IDLE
  always_comb begin
    next_state = state;
    hdr_done   = 1'b0;
    word_done  = 1'b0;
    if (cs_rise && (state != S_IDLE)) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cs_fall) next_state = S_HDR;
        S_HDR: begin
          if (sclk_rise && (cnt == HDR_LAST)) begin
            hdr_done = 1'b1;
            case (hdr_next[HDR_W-1 -: 3])
              3'b001, 3'b011: next_state = S_WR;
              3'b010, 3'b100: next_state = S_RD;
              default:        next_state = S_IGN;
            endcase
          end
        end
        S_WR, S_RD: begin
          if (sclk_rise && (cnt == WORD_LAST)) begin
            word_done = 1'b1;
            if (!burst) next_state = S_IGN;
          end
        end
        default: next_state = state;
      endcase
    end
  end

  // Datapath: shifters, counters, address pointer, memory and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      hdr_shift   <= '0;
      wr_shift    <= '0;
      rd_shift    <= '0;
      cnt         <= '0;
      addr        <= '0;
      burst       <= 1'b0;
      past_end    <= 1'b0;
      commit_pend <= 1'b0;
      load_pend   <= 1'b0;
      miso        <= 1'b0;
      cmd_err     <= 1'b0;
      abort       <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      load_pend   <= 1'b0;
      cmd_err     <= hdr_done && (next_state == S_IGN);
      abort       <= cs_rise && ((state == S_HDR) ||
                     (((state == S_WR) || (state == S_RD)) && (cnt != '0)));

      // A completed write word is committed even if cs rises in this cycle.
      if (commit_pend && !past_end) mem[addr] <= wr_shift;

      // Burst pointer advance; without wrap it parks at the last address.
      if ((commit_pend && burst) || (word_done && (state == S_RD) && burst)) begin
        if (&addr) begin
          if (BURST_WRAP != 0) addr <= '0;
          else                 past_end <= 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end

      if (cs_rise) begin
        cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              cnt       <= '0;
              hdr_shift <= '0;
            end
          end
          S_HDR: begin
            if (sclk_rise) begin
              hdr_shift <= hdr_next[HDR_W-2:0];
              if (hdr_done) begin
                cnt       <= '0;
                addr      <= hdr_next[ADDR_W-1:0];
                burst     <= (hdr_next[HDR_W-1 -: 3] == 3'b011) ||
                             (hdr_next[HDR_W-1 -: 3] == 3'b100);
                past_end  <= 1'b0;
                load_pend <= (next_state == S_RD);
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_WR: begin
            if (sclk_rise) begin
              wr_shift <= {wr_shift[DATA_W-2:0], mosi_s};
              if (word_done) begin
                cnt         <= '0;
                commit_pend <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_RD: begin
            if (sclk_rise) begin
              if (word_done) begin
                cnt       <= '0;
                load_pend <= burst;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            if (sclk_fall) begin
              miso     <= rd_shift[DATA_W-1];
              rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
            end
          end
          default: cnt <= cnt;
        endcase
      end

      if (load_pend) rd_shift <= past_end ? '0 : mem[addr];

      if (next_state != S_RD) miso <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_mem_burst.md
Name: spi_slave_mem_burst

Overview:
- Parametrised SPI (mode 0) slave with an on-chip register-file memory.
- Successor to the fixed 8-bit data / 5-bit address SPI slave memory.
- Adds generic ADDR_W/DATA_W, burst read as well as burst write, configurable burst wrap, invalid-command rejection and defined CS-abort behaviour.
- Runs on the system clock and oversamples the SPI pins; it is the memory target used by the SPI master benches.

Parameters:
- ADDR_W, 5: address field width. Memory depth = 2**ADDR_W.
- DATA_W, 8: word width, shifted MSB first.
- BURST_WRAP, 0:
  - 0: a burst stops at address 2**ADDR_W-1. Extra write words are discarded; extra read words return 0.
  - 1: the address wraps to 0.
- SYNC_STAGES, 2: synchroniser depth on cs, sclk and mosi (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cs  in  1  active-low chip select (asynchronous to clk)
- sclk  in  1  SPI serial clock, idle low (asynchronous to clk)
- mosi  in  1  master-out slave-in data
- miso  out  1  slave-out data; driven 0 when not reading (no tri-state)
- busy  out  1  high while a frame is in progress (synchronised cs low and state != IDLE)
- cmd_err  out  1  one-clk pulse when an invalid opcode has been decoded
- abort  out  1  one-clk pulse when cs rises mid-word or mid-header

Behaviour:
- Reset state:
  - All memory words = 0; state = IDLE.
  - miso = 0, busy = 0, cmd_err = 0, abort = 0.
  - Shift registers and bit counters cleared.
- Input handling:
  - cs, sclk and mosi each pass through a SYNC_STAGES flop synchroniser.
  - The sclk rising and falling edges are detected on the synchronised copy.
- Timing requirement: sclk high time and low time are each ≥ 4 clk periods. Slower is allowed.
- Sampling: mosi is sampled on the sclk rising edge. miso is updated on the sclk falling edge.
- Frame header: 3-bit opcode then ADDR_W-bit address, both MSB first. The header is complete on rising edge number 3+ADDR_W.
- Opcodes:
  - 001 = single write
  - 010 = single read
  - 011 = burst write
  - 100 = burst read
  - 000, 101, 110, 111 = invalid
- States:
  - IDLE: on synchronised cs falling → HDR.
  - HDR: shift in the header. On completion, go to WR (001/011), RD (010/100), or IGNORE (invalid, with a cmd_err pulse).
  - WR: shift in DATA_W bits, then commit mem[addr] in the clk cycle after the last rising edge.
    - Single write → IGNORE.
    - Burst write → addr+1 and stay in WR.
  - RD: the word mem[addr] is loaded into the output shifter one clk after header completion. The MSB is driven on the next sclk falling edge, so it is valid for the master's next rising edge.
    - After DATA_W bits, a single read → IGNORE.
    - After DATA_W bits, a burst read → addr+1, the next word is loaded, and the state stays in RD.
  - IGNORE: miso = 0; all sclk edges are ignored until cs rises.
- Boundaries and simultaneous events:
  - Burst at last address, BURST_WRAP = 0: the word for address 2**ADDR_W-1 is committed or returned. Subsequent words are not written; read words shift out as 0.
  - Burst at last address, BURST_WRAP = 1: the next address is 0.
  - Synchronised cs rising in any non-IDLE state:
    - Return to IDLE next clk and set miso = 0.
    - Discard any partial word; the memory is untouched.
    - Pulse abort if the rise is in HDR, or mid-word in WR/RD (bit count ≠ 0).
    - No abort on a clean word boundary, and none in IGNORE.
  - cs falling while already low: no effect. A new frame requires cs high for ≥ 1 synchronised clk.
  - A commit cycle and a cs rise in the same clk: the commit completes, because the word is whole.
  - rst asserted mid-frame:
    - Immediate return to the reset state on the next clk.
    - After reset, the frame in progress is ignored. The slave waits for cs high before accepting a new cs fall.
  - sclk edges while cs is high are ignored.

Test Plan:
1. Reset, single write 001_00001 with data 0x01, then single read 010_00001 → miso returns 0x01 MSB first; cmd_err = 0, abort = 0.
2. Burst write 011_10000 with 16 words A1,B2,C3,D4,E5,F6,12,34,56,78,9A,BC,DE,F0,AB,CD; then burst read 100_10000 for 16 words → same sequence returned in order.
3. BURST_WRAP = 0, burst write at 0x1E with A1,B2,C3,D4 → mem[0x1E] = A1, mem[0x1F] = B2, mem[0x00] = 00 and mem[0x01] = 00 (unchanged). Repeat with BURST_WRAP = 1 → mem[0x00] = C3, mem[0x01] = D4.
4. Invalid opcode 111_00001 followed by 8 data bits 0xFF → cmd_err pulses once after rising edge 8, mem[0x01] unchanged, miso stays 0 for the whole frame.
5. Single write 001_00010 with data 0xAA, cs raised after 4 data bits → abort pulses, mem[0x02] remains 0x00; a following read of 0x02 returns 0x00 and the next frame decodes normally.
6. rst pulsed during the data phase of a write to 0x03 → all outputs 0, mem cleared; the remaining sclk edges of that frame are ignored; a fresh frame after cs high/low writes correctly.
